// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit and receive stages.
// Frame: WORD_W data bits MSB first, then one delimiter bit.
package serial_pkg;

  localparam int WORD_W = 8;
  localparam int FRAME_BITS = 9;
  localparam logic DELIM_BIT = 1'b0;

  typedef enum logic {
    SEND_DATA,
    SEND_DELIM
  } tx_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding the serial transmit frame loader.
// DEPTH must be a power of two so pointers wrap naturally.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WORD_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic [WORD_W-1:0]      o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  // A full FIFO refuses pushes even if a pop frees a slot this cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_transmit.sv
// Serializer: FIFO bytes out MSB first plus a delimiter bit,
// with fill frames whenever nothing is queued at a boundary.
module serial_transmit
  import serial_pkg::*;
#(
  parameter int                DEPTH        = 4,
  parameter int                CLKS_PER_BIT = 1,
  parameter logic [WORD_W-1:0] FILL_WORD    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   txd,
  output logic                   frame_start,
  output logic                   word_done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int DW = cnt_w(CLKS_PER_BIT);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(WORD_W - 1);
  localparam logic [3:0] DELIM_CNT = 4'(FRAME_BITS - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [3:0]        r_bit_cnt;
  logic [DW-1:0]     r_div_cnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_is_fill;

  logic              w_bit_end;
  logic              w_reload;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_head;

  assign w_bit_end = (r_div_cnt == DIV_LAST);
  assign w_reload  = (r_state == SEND_DELIM) && w_bit_end;
  assign w_push    = in_valid && !w_full;
  assign w_pop     = w_reload && !w_empty;

  serial_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (in_data),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SEND_DATA;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SEND_DATA: begin
        if (w_bit_end && (r_bit_cnt == LAST_DATA))
          w_state_nxt = SEND_DELIM;
      end
      SEND_DELIM: begin
        if (w_bit_end) w_state_nxt = SEND_DATA;
      end
      default: w_state_nxt = SEND_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= FILL_WORD;
      r_is_fill <= 1'b1;
    end else begin
      r_div_cnt <= w_bit_end ? '0 : r_div_cnt + 1'b1;
      if (w_reload) begin
        r_bit_cnt <= '0;
        r_shift   <= w_empty ? FILL_WORD : w_head;
        r_is_fill <= w_empty;
      end else if (w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_state == SEND_DATA)
          r_shift <= {r_shift[WORD_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    txd         = r_shift[WORD_W-1];
    frame_start = 1'b0;
    word_done   = 1'b0;
    in_ready    = !w_full;
    if (r_state == SEND_DELIM) txd = DELIM_BIT;
    frame_start = (r_bit_cnt == '0) && (r_div_cnt == '0);
    word_done   = w_reload && !r_is_fill
                  && (r_bit_cnt == DELIM_CNT);
  end

endmodule

// File: tb/tb_serial_transmit.sv
// Bench for serial_transmit: bit-level deframer and scoreboard
// on a CLKS_PER_BIT=1 instance and a CLKS_PER_BIT=3 instance.
module tb_serial_transmit;

  localparam logic [7:0] FILL = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data, in_data3;
  logic       in_valid, in_valid3;
  logic       in_ready, in_ready3;
  logic       txd, txd3;
  logic       frame_start, frame_start3;
  logic       word_done, word_done3;
  logic [2:0] fifo_count, fifo_count3;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp3_q[$];
  int cyc, c3, m_cnt;
  logic fill_exp;
  logic [7:0] sh1, sh3;

  always #5 clk = ~clk;

  serial_transmit #(
    .DEPTH(4), .CLKS_PER_BIT(1), .FILL_WORD(FILL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .txd(txd),
    .frame_start(frame_start), .word_done(word_done),
    .fifo_count(fifo_count)
  );

  serial_transmit #(
    .DEPTH(4), .CLKS_PER_BIT(3), .FILL_WORD(FILL)
  ) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .txd(txd3),
    .frame_start(frame_start3), .word_done(word_done3),
    .fifo_count(fifo_count3)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, want);
    end
  endtask

  task automatic tick();
    logic hs, pop, hs3;
    logic [7:0] d, d3, b;
    hs  = rst && in_valid && in_ready;
    pop = rst && (cyc == 8) && (m_cnt > 0);
    if (rst && (cyc == 8)) fill_exp = (m_cnt == 0);
    hs3 = rst && in_valid3 && in_ready3;
    d   = in_data;
    d3  = in_data3;
    @(negedge clk);
    if (!rst) begin
      check("rst_txd", 32'(txd), 32'(1));
      check("rst_fs", 32'(frame_start), 32'(1));
      check("rst_wd", 32'(word_done), 32'(0));
      check("rst_cnt", 32'(fifo_count), 32'(0));
      check("rst_rdy", 32'(in_ready), 32'(1));
      check("rst_txd3", 32'(txd3), 32'(1));
      exp_q.delete();
      exp3_q.delete();
      m_cnt = 0;
      fill_exp = 1'b1;
      cyc = 0;
      c3 = 0;
      sh1[7] = txd;
      sh3[7] = txd3;
    end else begin
      if (hs) begin
        exp_q.push_back(d);
        m_cnt++;
      end
      if (pop) m_cnt--;
      if (hs3) exp3_q.push_back(d3);
      check("count", 32'(fifo_count), 32'(m_cnt));
      check("ready", 32'(in_ready), 32'(m_cnt < 4));
      if (frame_start) begin
        check("frame_len", 32'(cyc), 32'(8));
        cyc = 0;
      end else cyc++;
      if (cyc < 8) sh1[3'(7 - cyc)] = txd;
      if (cyc == 8) begin
        check("delim", 32'(txd), 32'(0));
        check("kind", 32'(word_done), 32'(!fill_exp));
        if (word_done) begin
          check("queued", 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("data", 32'(sh1), 32'(b));
          end
        end else check("fill", 32'(sh1), 32'(FILL));
      end else check("wd_idle", 32'(word_done), 32'(0));
      if (frame_start3) begin
        check("frame_len3", 32'(c3), 32'(26));
        c3 = 0;
      end else c3++;
      if (c3 < 24) begin
        if (c3 % 3 == 0) sh3[3'(7 - c3 / 3)] = txd3;
        else check("hold3", 32'(txd3), 32'(sh3[3'(7 - c3 / 3)]));
      end else check("delim3", 32'(txd3), 32'(0));
      if (c3 == 26) begin
        if (word_done3) begin
          check("queued3", 32'(exp3_q.size() > 0), 32'(1));
          if (exp3_q.size() > 0) begin
            b = exp3_q.pop_front();
            check("data3", 32'(sh3), 32'(b));
          end
        end else check("fill3", 32'(sh3), 32'(FILL));
      end else check("wd_idle3", 32'(word_done3), 32'(0));
    end
  endtask

  task automatic wait_cyc(input int n);
    int k = 0;
    while (cyc != n && k < 100) begin
      tick();
      k++;
    end
    check("sync", 32'(cyc), 32'(n));
  endtask

  task automatic push(input logic [7:0] b);
    int k = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    check("ready_wait", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push3(input logic [7:0] b);
    int k = 0;
    in_data3 = b;
    in_valid3 = 1'b1;
    while (!in_ready3 && k < 100) begin
      tick();
      k++;
    end
    check("ready_wait3", 32'(in_ready3), 32'(1));
    tick();
    in_valid3 = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() > 0 || exp3_q.size() > 0) && k < 400) begin
      tick();
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    check("drain3", 32'(exp3_q.size()), 32'(0));
  endtask

  initial begin
    rst = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    in_data3 = '0;
    in_valid3 = 1'b0;
    cyc = 0;
    c3 = 0;
    m_cnt = 0;
    fill_exp = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (27) tick();

    wait_cyc(4);
    push(8'h3C);
    drain();

    wait_cyc(0);
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("full_cnt", 32'(fifo_count), 32'(4));
    check("full_rdy", 32'(in_ready), 32'(0));
    push(8'h05);
    drain();

    wait_cyc(8);
    push(8'h5A);
    drain();

    wait_cyc(2);
    push3(8'hF0);
    drain();
    repeat (30) tick();

    wait_cyc(0);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_cyc(8);
    tick();
    wait_cyc(4);
    check("abort_cnt", 32'(fifo_count), 32'(2));
    rst = 1'b0;
    #1;
    check("abort_txd", 32'(txd), 32'(1));
    check("abort_cnt0", 32'(fifo_count), 32'(0));
    check("abort_rdy", 32'(in_ready), 32'(1));
    check("abort_fs", 32'(frame_start), 32'(1));
    tick();
    tick();
    rst = 1'b1;
    repeat (30) tick();

    push(8'h81);
    push(8'h7E);
    drain();
    repeat (10) tick();

    check("end_q", 32'(exp_q.size()), 32'(0));
    check("end_cnt3", 32'(fifo_count3), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
